// File: rtl/product_accumulator.sv
// product_accumulator: sums N_SAMPLES unsigned 8-bit products into a
// saturating accumulator over a valid/ready handshake, then pulses done.
module product_accumulator #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       p,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             ovf
);
  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE_S} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W:0]   sum;
  logic             xfer;

  // One extra bit catches the carry-out that signals saturation.
  assign sum  = {1'b0, acc} + (ACC_W+1)'(p);
  assign xfer = in_valid & in_ready;

  // Next-state and state-decoded handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && cnt == CNT_LAST) state_nxt = DONE_S;
      end
      DONE_S: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus accumulator/count/overflow datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (xfer) begin
        cnt <= cnt + CNT_W'(1);
        if (sum[ACC_W]) begin
          acc <= '1;
          ovf <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: two instances (default params and ACC_W=10/N=5)
// share in_valid/p; each has its own start so the idle one ignores traffic.
module tb_product_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, in_valid;
  logic [7:0]  p;
  logic        ready_a, busy_a, done_a, ovf_a;
  logic        ready_b, busy_b, done_b, ovf_b;
  logic [11:0] acc_a;
  logic [9:0]  acc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .p(p),
    .in_ready(ready_a), .acc(acc_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  product_accumulator #(.N_SAMPLES(5), .ACC_W(10)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .p(p),
    .in_ready(ready_b), .acc(acc_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  typedef struct {
    int acc; int busy; int done; int ovf; int ready;
  } obs_t;

  typedef struct {
    int    which;
    int    n;
    int    pv[5];
    int    gap[5];
    int    exp_acc;
    int    exp_ovf;
    string nm;
  } vec_t;

  function automatic obs_t obs(input int which);
    obs_t o;
    if (which == 0) begin
      o.acc = int'(acc_a); o.busy = int'(busy_a); o.done = int'(done_a);
      o.ovf = int'(ovf_a); o.ready = int'(ready_a);
    end else begin
      o.acc = int'(acc_b); o.busy = int'(busy_b); o.done = int'(done_b);
      o.ovf = int'(ovf_b); o.ready = int'(ready_b);
    end
    return o;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int which);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic xfer(input int pv);
    in_valid = 1'b1;
    p = 8'(pv);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic int sat(input int s, input int maxv);
    return (s > maxv) ? maxv : s;
  endfunction

  // Full run: start, n transfers with gaps, done pulse, return to IDLE.
  // Reference: running sum clipped at the accumulator maximum.
  task automatic run(input int which, input int n, input int pv[5],
                     input int gap[5], input string nm, output obs_t fin);
    int   sum, maxv;
    obs_t o;
    maxv = (which == 0) ? 4095 : 1023;
    do_start(which);
    o = obs(which);
    check({nm, " clr_acc"}, o.acc, 0);
    check({nm, " clr_ovf"}, o.ovf, 0);
    sum = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        tick();
        o = obs(which);
        check({nm, " gap_acc"}, o.acc, sat(sum, maxv));
        check({nm, " gap_done"}, o.done, 0);
      end
      o = obs(which);
      check({nm, " ready"}, o.ready, 1);
      xfer(pv[i]);
      sum += pv[i];
      o = obs(which);
      check({nm, " acc"}, o.acc, sat(sum, maxv));
      if (i < n - 1) check({nm, " early_done"}, o.done, 0);
      else begin
        check({nm, " done"}, o.done, 1);
        check({nm, " done_ready"}, o.ready, 0);
      end
    end
    o = obs(which);
    check({nm, " ovf"}, o.ovf, (sum > maxv) ? 1 : 0);
    tick();
    o = obs(which);
    check({nm, " done_drop"}, o.done, 0);
    check({nm, " busy_drop"}, o.busy, 0);
    check({nm, " hold_acc"}, o.acc, sat(sum, maxv));
    fin = o;
  endtask

  vec_t tbl[4];

  initial begin
    obs_t o;
    int   pv[5];
    int   gp[5];

    tbl[0].which = 0; tbl[0].n = 4; tbl[0].pv = '{225, 225, 225, 225, 0};
    tbl[0].gap = '{0, 0, 0, 0, 0}; tbl[0].exp_acc = 900; tbl[0].exp_ovf = 0;
    tbl[0].nm = "b2b225";
    tbl[1].which = 0; tbl[1].n = 4; tbl[1].pv = '{10, 20, 30, 40, 0};
    tbl[1].gap = '{0, 0, 2, 1, 3}; tbl[1].exp_acc = 100; tbl[1].exp_ovf = 0;
    tbl[1].nm = "gaps";
    tbl[2].which = 1; tbl[2].n = 5; tbl[2].pv = '{225, 225, 225, 225, 225};
    tbl[2].gap = '{0, 0, 0, 0, 0}; tbl[2].exp_acc = 1023; tbl[2].exp_ovf = 1;
    tbl[2].nm = "sat";
    tbl[3].which = 1; tbl[3].n = 5; tbl[3].pv = '{1, 1, 1, 1, 1};
    tbl[3].gap = '{0, 1, 0, 0, 0}; tbl[3].exp_acc = 5; tbl[3].exp_ovf = 0;
    tbl[3].nm = "after_sat";

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; p = '0;
    tick(); tick();
    rst = 1'b0;
    o = obs(0);
    check("rst acc", o.acc, 0);
    check("rst busy", o.busy, 0);
    check("rst done", o.done, 0);
    check("rst ovf", o.ovf, 0);
    check("rst ready", o.ready, 0);
    o = obs(1);
    check("rst_b acc", o.acc, 0);
    check("rst_b ready", o.ready, 0);

    // Spec scenarios from a table.
    for (int t = 0; t < 4; t++) begin
      run(tbl[t].which, tbl[t].n, tbl[t].pv, tbl[t].gap, tbl[t].nm, o);
      check({tbl[t].nm, " tbl_acc"}, o.acc, tbl[t].exp_acc);
      check({tbl[t].nm, " tbl_ovf"}, o.ovf, tbl[t].exp_ovf);
    end

    // start with in_valid in IDLE must not consume p.
    start_a = 1'b1; in_valid = 1'b1; p = 8'd99;
    tick();
    start_a = 1'b0; in_valid = 1'b0;
    o = obs(0);
    check("sv acc0", o.acc, 0);
    check("sv busy", o.busy, 1);
    for (int i = 0; i < 4; i++) xfer(1);
    o = obs(0);
    check("sv acc4", o.acc, 4);
    check("sv done", o.done, 1);
    tick();

    // start mid-run is ignored.
    do_start(0);
    xfer(50); xfer(50);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    o = obs(0);
    check("mid acc", o.acc, 100);
    check("mid busy", o.busy, 1);
    xfer(50);
    o = obs(0);
    check("mid nodone", o.done, 0);
    xfer(50);
    o = obs(0);
    check("mid acc200", o.acc, 200);
    check("mid done", o.done, 1);
    start_a = 1'b1;                 // start during DONE also ignored
    tick();
    start_a = 1'b0;
    o = obs(0);
    check("mid done1", o.done, 0);
    check("mid idle", o.busy, 0);
    check("mid hold", o.acc, 200);

    // Reset mid-run discards the partial sum; B saturates first to see ovf clear.
    do_start(1);
    for (int i = 0; i < 5; i++) xfer(225);
    tick();
    do_start(0);
    xfer(70); xfer(80);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = obs(0);
    check("rr acc", o.acc, 0);
    check("rr busy", o.busy, 0);
    check("rr done", o.done, 0);
    check("rr ovf", o.ovf, 0);
    o = obs(1);
    check("rr_b ovf", o.ovf, 0);
    pv = '{7, 8, 9, 10, 0}; gp = '{0, 0, 0, 0, 0};
    run(0, 4, pv, gp, "post_rst", o);
    check("post_rst sum", o.acc, 34);

    // Randomized runs against the clipped-sum reference.
    for (int r = 0; r < 24; r++) begin
      int w;
      w = int'($urandom_range(1, 0));
      for (int i = 0; i < 5; i++) begin
        pv[i] = int'($urandom_range(225, 0));
        gp[i] = int'($urandom_range(3, 0));
      end
      if ($urandom_range(3, 0) == 0) pv[0] = 225;
      run(w, (w == 0) ? 4 : 5, pv, gp, $sformatf("rnd%0d", r), o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
